// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its boot loader.
package imem_pkg;

  localparam int          IMEM_DEPTH = 8;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    LOAD,
    RUN
  } boot_state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot sequencer: fills instruction memory with NOPs, streams a program in
// over valid/ready, then releases the core from reset.
//
// state | meaning
// IDLE  | core held in reset, waiting for load_start
// CLEAR | writing NOP_WORD to every word, one per cycle
// LOAD  | accepting program words from the loader
// RUN   | core released; load_start restarts the sequence
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH    = IMEM_DEPTH,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              core_run,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(DEPTH - 1);

  boot_state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      core_reset <= 1'b1;
      core_run   <= 1'b0;
      load_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          // The first clear write is issued on the same edge that sees
          // load_start, so NOPs land in cycles 1..DEPTH.
          if (load_start) begin
            state      <= CLEAR;
            core_reset <= 1'b1;
            core_run   <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            mem_we     <= 1'b1;
            mem_waddr  <= '0;
            mem_wdata  <= NOP_WORD;
          end
        end
        CLEAR: begin
          if (mem_waddr == ADDR_LAST) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            word_count <= '0;
          end else begin
            mem_we    <= 1'b1;
            mem_waddr <= mem_waddr + 1'b1;
            mem_wdata <= NOP_WORD;
          end
        end
        LOAD: begin
          if (load_valid && load_ready) begin
            mem_we     <= 1'b1;
            mem_waddr  <= word_count[ADDR_W-1:0];
            mem_wdata  <= load_data;
            word_count <= word_count + 1'b1;
            // Final write and core release share a cycle; the core's first
            // fetch happens at the following edge.
            if (load_last || word_count == CNT_LAST) begin
              state      <= RUN;
              load_ready <= 1'b0;
              core_reset <= 1'b0;
              core_run   <= 1'b1;
              overflow   <= !load_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
